// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// nn_pkg : shared states, default layer sizes and width helpers   (rev 1.0)
// ============================================================================
package nn_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_MAC   = 3'd2,
      S_DRAIN = 3'd3,
      S_WB    = 3'd4,
      S_SCORE = 3'd5,
      S_DONE  = 3'd6
   } nn_state_t;

   localparam int NN_N_SAMPLES = 750;
   localparam int NN_N_IN      = 62;
   localparam int NN_N_HID     = 30;
   localparam int NN_N_OUT     = 10;
   localparam int NN_ACC_W     = 32;
   localparam int NN_CNT_W     = 11;

   // Layer 1 weights follow layer 0 contiguously in the weight ROM.
   localparam int NN_W_BASE_L0 = 0;
   localparam int NN_W_BASE_L1 = NN_N_IN * NN_N_HID;

   function automatic int clog2m(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nn_argmax_tracker.sv
`default_nettype none
// ============================================================================
// nn_argmax_tracker : running strict signed max over output neurons (rev 1.0)
// ============================================================================
module nn_argmax_tracker #(
   parameter int ACC_W = 32,
   parameter int IDX_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_i,
   input  logic                    first_i,
   input  logic [IDX_W-1:0]        idx_i,
   input  logic signed [ACC_W-1:0] value_i,
   output logic [IDX_W-1:0]        best_idx_o
);

   logic signed [ACC_W-1:0] best_q;
   logic [IDX_W-1:0]        best_idx_q;

   // Strict compare keeps the lowest index on ties.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_q     <= '0;
         best_idx_q <= '0;
      end else if (load_i && (first_i || (value_i > best_q))) begin
         best_q     <= value_i;
         best_idx_q <= idx_i;
      end
   end

   assign best_idx_o = best_idx_q;

endmodule
`default_nettype wire

// File: rtl/nn_sequencer.sv
`default_nettype none
// ============================================================================
// nn_sequencer : walks sample/layer/neuron/input, drives MAC datapath, scores
// rev 1.0
// ============================================================================
module nn_sequencer
   import nn_pkg::*;
#(
   parameter int N_SAMPLES = NN_N_SAMPLES,
   parameter int N_IN      = NN_N_IN,
   parameter int N_HID     = NN_N_HID,
   parameter int N_OUT     = NN_N_OUT,
   parameter int ACC_W     = NN_ACC_W,
   parameter int CNT_W     = NN_CNT_W
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            start,
   output logic                                            busy,
   output logic                                            done,
   output logic [clog2m(N_SAMPLES*N_IN)-1:0]               x_addr,
   output logic [clog2m(N_HID)-1:0]                        act_raddr,
   output logic                                            in_sel,
   output logic [clog2m(N_IN*N_HID+N_HID*N_OUT)-1:0]       w_addr,
   output logic [clog2m(N_SAMPLES)-1:0]                    label_addr,
   output logic                                            mac_clr,
   output logic                                            mac_en,
   output logic                                            act_we,
   output logic [clog2m(N_HID)-1:0]                        act_waddr,
   input  logic signed [ACC_W-1:0]                         mac_result,
   input  logic [clog2m(N_OUT)-1:0]                        label,
   output logic [CNT_W-1:0]                                correct_count
);

   localparam int XW = clog2m(N_SAMPLES*N_IN);
   localparam int HW = clog2m(N_HID);
   localparam int WW = clog2m(N_IN*N_HID+N_HID*N_OUT);
   localparam int SW = clog2m(N_SAMPLES);
   localparam int LW = clog2m(N_OUT);
   localparam int IW = clog2m(max2(N_IN, N_HID));
   localparam int NW = clog2m(max2(N_HID, N_OUT));

   nn_state_t        state_q;
   logic [SW-1:0]    sample_q;
   logic             layer_q;
   logic [NW-1:0]    neuron_q;
   logic [IW-1:0]    in_idx_q;
   logic [XW-1:0]    xbase_q;
   logic [WW-1:0]    waddr_q;
   logic             busy_q, done_q, mac_clr_q, mac_en_q, act_we_q;
   logic [CNT_W-1:0] correct_q, correct_d;
   logic [LW-1:0]    best_idx;
   logic             in_last, neuron_last, sample_last;

   assign in_last     = layer_q ? (in_idx_q == IW'(N_HID-1)) : (in_idx_q == IW'(N_IN-1));
   assign neuron_last = layer_q ? (neuron_q == NW'(N_OUT-1)) : (neuron_q == NW'(N_HID-1));
   assign sample_last = (sample_q == SW'(N_SAMPLES-1));
   assign correct_d   = ((best_idx == label) && (correct_q != {CNT_W{1'b1}})) ?
                        correct_q + 1'b1 : correct_q;

   nn_argmax_tracker #(.ACC_W(ACC_W), .IDX_W(LW)) u_argmax (
      .clk        (clk),
      .rst        (rst),
      .load_i     ((state_q == S_WB) && layer_q),
      .first_i    (neuron_q == '0),
      .idx_i      (LW'(neuron_q)),
      .value_i    (mac_result),
      .best_idx_o (best_idx)
   );

   // Weight addresses run contiguously through both layers, so a plain counter suffices.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sample_q  <= '0;
         layer_q   <= 1'b0;
         neuron_q  <= '0;
         in_idx_q  <= '0;
         xbase_q   <= '0;
         waddr_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mac_clr_q <= 1'b0;
         mac_en_q  <= 1'b0;
         act_we_q  <= 1'b0;
         correct_q <= '0;
      end else begin
         mac_en_q  <= (state_q == S_MAC);
         mac_clr_q <= 1'b0;
         act_we_q  <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sample_q  <= '0;
                  layer_q   <= 1'b0;
                  neuron_q  <= '0;
                  in_idx_q  <= '0;
                  xbase_q   <= '0;
                  waddr_q   <= '0;
                  correct_q <= '0;
                  busy_q    <= 1'b1;
                  mac_clr_q <= 1'b1;
                  state_q   <= S_CLR;
               end
            end
            S_CLR: begin
               state_q <= S_MAC;
            end
            S_MAC: begin
               waddr_q <= waddr_q + 1'b1;
               if (in_last) begin
                  in_idx_q <= '0;
                  state_q  <= S_DRAIN;
               end else begin
                  in_idx_q <= in_idx_q + 1'b1;
               end
            end
            S_DRAIN: begin
               act_we_q <= ~layer_q;
               state_q  <= S_WB;
            end
            S_WB: begin
               if (!neuron_last) begin
                  neuron_q  <= neuron_q + 1'b1;
                  mac_clr_q <= 1'b1;
                  state_q   <= S_CLR;
               end else if (!layer_q) begin
                  layer_q   <= 1'b1;
                  neuron_q  <= '0;
                  mac_clr_q <= 1'b1;
                  state_q   <= S_CLR;
               end else begin
                  state_q <= S_SCORE;
               end
            end
            S_SCORE: begin
               correct_q <= correct_d;
               if (!sample_last) begin
                  sample_q  <= sample_q + 1'b1;
                  xbase_q   <= xbase_q + XW'(N_IN);
                  layer_q   <= 1'b0;
                  neuron_q  <= '0;
                  waddr_q   <= '0;
                  mac_clr_q <= 1'b1;
                  state_q   <= S_CLR;
               end else begin
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign mac_clr       = mac_clr_q;
   assign mac_en        = mac_en_q;
   assign act_we        = act_we_q;
   assign in_sel        = layer_q;
   assign x_addr        = xbase_q + XW'(in_idx_q);
   assign act_raddr     = HW'(in_idx_q);
   assign w_addr        = waddr_q;
   assign label_addr    = sample_q;
   assign act_waddr     = HW'(neuron_q);
   assign correct_count = correct_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_sequencer.sv
`default_nettype none
// ============================================================================
// tb_nn_sequencer : schedule-expansion model compared against nn_sequencer
// rev 1.0
// ============================================================================
module tb_nn_sequencer;

   localparam int S    = 5;
   localparam int NI   = 4;
   localparam int NH   = 2;
   localparam int NO   = 3;
   localparam int CW   = 2;
   localparam int CMAX = 3;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic signed [31:0] mac_result = '0;
   logic [1:0]         label = '0;
   logic               busy, done, in_sel, mac_clr, mac_en, act_we;
   logic [4:0]         x_addr;
   logic [0:0]         act_raddr, act_waddr;
   logic [3:0]         w_addr;
   logic [2:0]         label_addr;
   logic [CW-1:0]      correct_count;

   always #5 clk = ~clk;

   nn_sequencer #(
      .N_SAMPLES(S), .N_IN(NI), .N_HID(NH), .N_OUT(NO), .ACC_W(32), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .x_addr(x_addr), .act_raddr(act_raddr), .in_sel(in_sel), .w_addr(w_addr),
      .label_addr(label_addr), .mac_clr(mac_clr), .mac_en(mac_en), .act_we(act_we),
      .act_waddr(act_waddr), .mac_result(mac_result), .label(label),
      .correct_count(correct_count)
   );

   // -1 in any field means "not meaningful this cycle".
   typedef struct {
      int busy, done, clr, en, we, sel, wa, xa, ra, aw, la, cc, mac, lab;
   } rec_t;

   rec_t exp_q[$];
   rec_t ce;
   int   outs [S][NO];
   int   labs [S];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   chk_on  = 1'b0;
   int   cyc     = 0;
   int   done_at = -1;
   int   done_cnt = 0;
   int   prev_wa = 0;
   int   issued[$];
   int   we_addr[$];

   task automatic chk(input string nm, input int act, input int expv);
      if (expv >= 0) begin
         n_tests++;
         if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
         end
      end
   endtask

   function automatic rec_t mk(input int b, input int cc);
      rec_t r;
      r.busy = b;  r.done = 0; r.clr = 0; r.en = 0; r.we = 0; r.sel = -1;
      r.wa = -1;   r.xa = -1;  r.ra = -1; r.aw = -1; r.la = -1; r.cc = cc;
      r.mac = int'($urandom);
      r.lab = int'($urandom_range(3));
      return r;
   endfunction

   // Expand one run into its cycle-by-cycle schedule, starting the cycle after start is taken.
   task automatic build();
      rec_t r;
      int cc, nl, nn, best;
      cc = 0;
      exp_q.delete();
      for (int s = 0; s < S; s++) begin
         for (int l = 0; l < 2; l++) begin
            nl = (l == 0) ? NI : NH;
            nn = (l == 0) ? NH : NO;
            for (int n = 0; n < nn; n++) begin
               r = mk(1, cc); r.clr = 1; r.sel = l; r.la = s; r.lab = labs[s];
               exp_q.push_back(r);
               for (int i = 0; i < nl; i++) begin
                  r = mk(1, cc); r.sel = l; r.la = s; r.lab = labs[s];
                  r.en = (i > 0) ? 1 : 0;
                  r.wa = ((l == 0) ? 0 : NI * NH) + n * nl + i;
                  if (l == 0) r.xa = s * NI + i;
                  else        r.ra = i;
                  exp_q.push_back(r);
               end
               r = mk(1, cc); r.en = 1; r.sel = l; r.la = s; r.lab = labs[s];
               exp_q.push_back(r);
               r = mk(1, cc); r.sel = l; r.la = s; r.lab = labs[s];
               r.we = (l == 0) ? 1 : 0;
               if (l == 0) r.aw = n;
               else        r.mac = outs[s][n];
               exp_q.push_back(r);
            end
         end
         r = mk(1, cc); r.sel = 1; r.la = s; r.lab = labs[s];
         exp_q.push_back(r);
         best = 0;
         for (int n = 1; n < NO; n++)
            if (outs[s][n] > outs[s][best]) best = n;
         if (best == labs[s] && cc < CMAX) cc++;
      end
      r = mk(1, cc); r.sel = 1;
      exp_q.push_back(r);
      r = mk(0, cc); r.done = 1;
      exp_q.push_back(r);
      r = mk(0, cc);
      exp_q.push_back(r);
      exp_q.push_back(r);
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         if (mac_en) issued.push_back(prev_wa);
         if (act_we) we_addr.push_back(int'(act_waddr));
         prev_wa = int'(w_addr);
         if (done) begin
            done_cnt++;
            done_at = cyc + 1;
         end
         if (cyc < exp_q.size()) begin
            ce = exp_q[cyc];
            chk("busy",          int'(busy),          ce.busy);
            chk("done",          int'(done),          ce.done);
            chk("mac_clr",       int'(mac_clr),       ce.clr);
            chk("mac_en",        int'(mac_en),        ce.en);
            chk("act_we",        int'(act_we),        ce.we);
            chk("in_sel",        int'(in_sel),        ce.sel);
            chk("w_addr",        int'(w_addr),        ce.wa);
            chk("x_addr",        int'(x_addr),        ce.xa);
            chk("act_raddr",     int'(act_raddr),     ce.ra);
            chk("act_waddr",     int'(act_waddr),     ce.aw);
            chk("label_addr",    int'(label_addr),    ce.la);
            chk("correct_count", int'(correct_count), ce.cc);
         end
         cyc++;
      end
   end

   task automatic run(input int n_cyc, input int start_at);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      cyc      = 0;
      done_at  = -1;
      done_cnt = 0;
      chk_on   = 1'b1;
      for (int k = 0; k < n_cyc && k < exp_q.size(); k++) begin
         mac_result = exp_q[k].mac;
         label      = 2'(exp_q[k].lab);
         start      = (k == start_at);
         @(posedge clk);
         #1;
      end
      start  = 1'b0;
      chk_on = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},       int'(busy),          0);
      chk({tag, "_done"},       int'(done),          0);
      chk({tag, "_mac_clr"},    int'(mac_clr),       0);
      chk({tag, "_mac_en"},     int'(mac_en),        0);
      chk({tag, "_act_we"},     int'(act_we),        0);
      chk({tag, "_in_sel"},     int'(in_sel),        0);
      chk({tag, "_x_addr"},     int'(x_addr),        0);
      chk({tag, "_w_addr"},     int'(w_addr),        0);
      chk({tag, "_act_raddr"},  int'(act_raddr),     0);
      chk({tag, "_act_waddr"},  int'(act_waddr),     0);
      chk({tag, "_label_addr"}, int'(label_addr),    0);
      chk({tag, "_count"},      int'(correct_count), 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_zero("reset");

      // Run A: every sample classified correctly (ties to lowest index, signed compare).
      outs = '{'{5, 5, 2}, '{-7, -3, -9}, '{1, 2, 3}, '{0, 4, 4}, '{-2, -2, -2}};
      labs = '{0, 1, 2, 1, 0};
      build();
      issued.delete();
      we_addr.delete();
      run(1000, -1);
      chk("runA_count_saturated", int'(correct_count), 3);
      chk("runA_done_cycle",      done_at,  S * 30 + 2);
      chk("runA_done_pulses",     done_cnt, 1);
      chk("runA_issue_count",     issued.size(), S * 14);
      for (int i = 0; i < 14 && i < issued.size(); i++)
         chk("runA_w_addr_seq", issued[i], i);
      chk("runA_act_we_count",    we_addr.size(), S * NH);
      if (we_addr.size() >= 2) begin
         chk("runA_act_waddr0", we_addr[0], 0);
         chk("runA_act_waddr1", we_addr[1], 1);
      end

      // Abort mid-MAC of sample 1, after sample 0 already scored.
      run(33, -1);
      rst = 1'b1;
      #1;
      chk_zero("mid_reset");
      @(negedge clk);
      rst = 1'b0;

      // Run B: mixed results, plus an ignored start pulse while busy.
      outs = '{'{5, 5, 2}, '{-7, -3, -9}, '{5, 5, 2}, '{9, -1, 9}, '{-1, -1, -2}};
      labs = '{1, 1, 0, 2, 1};
      build();
      run(1000, 70);
      chk("runB_count",       int'(correct_count), 2);
      chk("runB_done_cycle",  done_at,  S * 30 + 2);
      chk("runB_done_pulses", done_cnt, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
- Control FSM that runs the fully-connected classifier datapath over a stored test set.
- Walks sample, layer, neuron and input indices, and issues ROM/RAM read addresses and MAC/activation strobes.
- Performs argmax over the output layer, compares it with the stored label, and accumulates `correct_count`.
- Sits above the MAC/activation datapath inside the network top; the top exposes only `clk`, `rst` and `correct_count`.

Parameters:
- N_SAMPLES, 750, number of test samples evaluated per run.
- N_IN, 62, input-layer width (features per sample).
- N_HID, 30, hidden-layer neuron count.
- N_OUT, 10, output-layer neuron count (classes).
- ACC_W, 32, signed accumulator width of `mac_result`.
- CNT_W, 11, width of `correct_count`.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin a run; sampled in IDLE only.
- busy, out, 1, high from the first cycle after an accepted start until DONE.
- done, out, 1, one-cycle pulse at end of run.
- x_addr, out, clog2(N_SAMPLES*N_IN), sample-memory read address.
- act_raddr, out, clog2(N_HID), hidden-activation buffer read address.
- in_sel, out, 1, datapath operand mux: 0 = sample memory (layer 0), 1 = activation buffer (layer 1).
- w_addr, out, clog2(N_IN*N_HID+N_HID*N_OUT), weight ROM address (layer 1 offset N_IN*N_HID).
- label_addr, out, clog2(N_SAMPLES), label memory address (= sample index).
- mac_clr, out, 1, clear accumulator.
- mac_en, out, 1, accumulate current operand pair.
- act_we, out, 1, write activated `mac_result` to hidden buffer.
- act_waddr, out, clog2(N_HID), hidden buffer write address.
- mac_result, in, ACC_W, signed accumulator value, valid in WB state.
- label, in, clog2(N_OUT), class label; 1-cycle read latency from `label_addr`.
- correct_count, out, CNT_W, number of correctly classified samples.

Behaviour:
- Reset (async, immediate): FSM=IDLE; all indices, busy, done, mac_clr, mac_en, act_we, in_sel, best, best_idx and correct_count = 0. All addresses = 0. Reset mid-run aborts with no residual state.
- All memories are synchronous with 1-cycle read latency. `mac_en` is the issue-valid signal registered once, so it aligns with the returned data.
- IDLE: on start=1, go to CLR; sample=0, layer=0, neuron=0, correct_count cleared to 0.
- start while not in IDLE is ignored.
- CLR (1 cycle): mac_clr=1; in_idx=0.
- MAC (Nl cycles, Nl = N_IN for layer 0, N_HID for layer 1):
  - Each cycle issue in_idx.
  - Layer 0: x_addr = sample*N_IN+in_idx.
  - Layer 1: act_raddr = in_idx.
  - w_addr = base(layer) + neuron*Nl + in_idx.
  - in_idx++. After in_idx = Nl-1, go to DRAIN.
- DRAIN (1 cycle): no issue; pipelined mac_en covers the last operand.
- WB (1 cycle), mac_result final:
  - Layer 0: act_we=1, act_waddr=neuron.
  - Layer 1: if neuron==0 or signed mac_result > best (strict), then best = mac_result, best_idx = neuron. Ties resolve to the lowest index.
  - Then: neuron++ and go to CLR; or, if last neuron of layer 0, set layer=1, neuron=0 and go to CLR; or, if last neuron of layer 1, go to SCORE.
- SCORE (1 cycle): label_addr has been held at the sample index since CLR, so label is stable.
  - If best_idx == label, correct_count++, saturating at 2^CNT_W-1.
  - If sample < N_SAMPLES-1: sample++, layer=0, neuron=0, go to CLR. Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=0 in the next cycle, return to IDLE. correct_count holds until the next accepted start or reset.
- Cycles per sample: N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1.
- Latency from start to done: N_SAMPLES × (cycles per sample) + 2.
- Strobes mac_clr, mac_en and act_we are never asserted in IDLE or DONE.

Decomposition:
- Shared package nn_pkg:
  - State enum (IDLE, CLR, MAC, DRAIN, WB, SCORE, DONE).
  - Layer-size localparams and derived address widths.
  - Layer base offsets for the weight ROM.
- One natural sub-module: nn_argmax_tracker, which holds best/best_idx and performs the strict signed compare and the first-neuron load.
- Index counters and FSM stay in nn_sequencer.

Test Plan:
- Reset: assert rst mid-MAC with 5 samples configured → all outputs 0 within the same cycle, FSM IDLE; a later start runs cleanly from sample 0.
- Timing: N_SAMPLES=1, N_IN=4, N_HID=2, N_OUT=3, start at cycle 0.
  - Required: done at cycle 32 (30 per sample + 2).
  - Required: w_addr sequence 0..7, then 8..13.
  - Required: act_we pulses at act_waddr 0 and 1.
- Argmax ties: output mac_results [5,5,2] → label 0 gives correct_count=1; label 1 gives 0.
- Signed compare: output mac_results [-7,-3,-9], label 1 → correct_count=1.
- Saturation: CNT_W=2, N_SAMPLES=5, all correct → correct_count=3, done pulses once.
- Start while busy: pulse start mid-run → ignored; correct_count not cleared; done timing unchanged.
